// File: rtl/clock_pkg.sv
// Shared types for the clock front-end: operating modes and button indices.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN  = 2'b00,
    MODE_SET  = 2'b01,
    MODE_HOLD = 2'b10
  } mode_e;

  localparam int BTN_MODE = 0;
  localparam int BTN_UP   = 1;
  localparam int BTN_DW   = 2;
  localparam int NUM_BTN  = 3;

endpackage

// File: rtl/clock_ctrl_if.sv
// Button inputs and counter-enable outputs of the clock front-end.
interface clock_ctrl_if;
  import clock_pkg::*;

  logic  btn_mode_n;
  logic  btn_up_n;
  logic  btn_dw_n;
  logic  ena;
  logic  ena_5hz;
  mode_e select_mode;
  logic  ena_up;
  logic  ena_dw;

  modport master (
    output btn_mode_n, btn_up_n, btn_dw_n,
    input  ena, ena_5hz, select_mode, ena_up, ena_dw
  );

  modport slave (
    input  btn_mode_n, btn_up_n, btn_dw_n,
    output ena, ena_5hz, select_mode, ena_up, ena_dw
  );

endinterface

// File: rtl/clock_ctrl_debounce.sv
// Two-flop synchronizer plus consecutive-sample debouncer for one active-low button.
module btn_debounce #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_n,
  output logic db_n,
  output logic press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          db_q, db_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any agreeing sample restarts the count, so short glitches never flip the state.
  always_comb begin
    cnt_d   = '0;
    db_d    = db_q;
    press_d = 1'b0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d    = ~db_q;
        press_d = db_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      db_q    <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_n;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign db_n  = db_q;
  assign press = press_q;

endmodule

// File: rtl/clock_ctrl.sv
// Clock front-end: 1 Hz / 5 Hz tick dividers, button debouncing and the RUN/SET/HOLD mode machine.
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int TICK_DIV  = 50000000,
  parameter int FAST_DIV  = 10000000,
  parameter int DB_CYCLES = 1000000
) (
  input  logic          clk,
  input  logic          rst,
  clock_ctrl_if.slave   bus
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int FW = $clog2(FAST_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [FW-1:0] FAST_LAST = FW'(FAST_DIV - 1);

  logic mode_db_unused, up_db_n, dw_db_n;
  logic press_mode, press_up, press_dw;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
    .clk(clk), .rst(rst), .raw_n(bus.btn_mode_n), .db_n(mode_db_unused), .press(press_mode)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .clk(clk), .rst(rst), .raw_n(bus.btn_up_n), .db_n(up_db_n), .press(press_up)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dw (
    .clk(clk), .rst(rst), .raw_n(bus.btn_dw_n), .db_n(dw_db_n), .press(press_dw)
  );

  mode_e         mode_q, mode_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [FW-1:0] fast_cnt_q, fast_cnt_d;
  logic          ena_q, ena_d;
  logic          ena_5hz_q, ena_5hz_d;
  logic          ena_up_q, ena_up_d;
  logic          ena_dw_q, ena_dw_d;
  logic          step_req, in_set_next;

  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      MODE_RUN:  if (press_mode) mode_d = MODE_SET;
      MODE_SET:  if (press_mode) mode_d = MODE_HOLD;
      MODE_HOLD: if (press_mode) mode_d = MODE_RUN;
      default:   mode_d = MODE_RUN;
    endcase
  end

  always_comb begin
    ena_d      = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = ena_d ? '0 : tick_cnt_q + TW'(1);

    // A fresh up/down press in SET restarts the repeat period so the first step is immediate.
    step_req   = (press_up | press_dw) & (mode_q == MODE_SET) & ~press_mode;
    ena_5hz_d  = (fast_cnt_q == FAST_LAST);
    fast_cnt_d = ena_5hz_d ? '0 : fast_cnt_q + FW'(1);
    if (step_req) begin
      ena_5hz_d  = 1'b1;
      fast_cnt_d = '0;
    end

    // Qualified by the next mode so leaving SET releases both requests on the same edge.
    in_set_next = (mode_d == MODE_SET);
    ena_up_d    = in_set_next ? up_db_n : 1'b1;
    ena_dw_d    = in_set_next ? (dw_db_n | ~up_db_n) : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= MODE_RUN;
      tick_cnt_q <= '0;
      fast_cnt_q <= '0;
      ena_q      <= 1'b0;
      ena_5hz_q  <= 1'b0;
      ena_up_q   <= 1'b1;
      ena_dw_q   <= 1'b1;
    end else begin
      mode_q     <= mode_d;
      tick_cnt_q <= tick_cnt_d;
      fast_cnt_q <= fast_cnt_d;
      ena_q      <= ena_d;
      ena_5hz_q  <= ena_5hz_d;
      ena_up_q   <= ena_up_d;
      ena_dw_q   <= ena_dw_d;
    end
  end

  assign bus.ena         = ena_q;
  assign bus.ena_5hz     = ena_5hz_q;
  assign bus.select_mode = mode_q;
  assign bus.ena_up      = ena_up_q;
  assign bus.ena_dw      = ena_dw_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed and random stimulus for clock_ctrl, checked every cycle against a window-based behavioural model.
module tb_clock_ctrl;
  import clock_pkg::*;

  localparam int TICK = 10;
  localparam int FAST = 4;
  localparam int DB   = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] raw = 3'b111;   // bit0 mode, bit1 up, bit2 down

  always #5 clk = ~clk;

  clock_ctrl_if bus();

  assign bus.btn_mode_n = raw[0];
  assign bus.btn_up_n   = raw[1];
  assign bus.btn_dw_n   = raw[2];

  clock_ctrl #(
    .TICK_DIV(TICK), .FAST_DIV(FAST), .DB_CYCLES(DB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int n_ena = 0;

  // Model state: edges since reset, raw history, debounced levels, pending press events.
  int         t;
  int         anchor;
  bit [2:0]   hist [0:4095];
  bit [2:0]   m_db;
  bit [2:0]   m_press;
  logic [1:0] m_mode;
  logic       exp_ena, exp_5hz, exp_up, exp_dw;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit raw_at(input int b, input int idx);
    if (idx <= 0) return 1'b1;
    return hist[idx][b];
  endfunction

  function automatic logic [1:0] next_mode(input logic [1:0] m);
    if (m == MODE_RUN) return MODE_SET;
    if (m == MODE_SET) return MODE_HOLD;
    return MODE_RUN;
  endfunction

  task automatic model_step();
    bit [2:0]   flip;
    bit [2:0]   press_now;
    bit         forced;
    logic [1:0] nmode;
    if (rst) begin
      t = 0; anchor = 0; m_db = 3'b111; m_press = 3'b000; m_mode = MODE_RUN;
      exp_ena = 1'b0; exp_5hz = 1'b0; exp_up = 1'b1; exp_dw = 1'b1;
    end else begin
      t++;
      if (t < 4096) hist[t] = raw;
      nmode  = m_press[0] ? next_mode(m_mode) : m_mode;
      forced = (m_press[1] | m_press[2]) && (m_mode == MODE_SET) && !m_press[0];
      if (forced) anchor = t;
      exp_ena = (t % TICK == 0);
      exp_5hz = forced || ((t > anchor) && ((t - anchor) % FAST == 0));
      exp_up  = (nmode == MODE_SET) ? m_db[1] : 1'b1;
      exp_dw  = (nmode == MODE_SET) ? (m_db[2] | ~m_db[1]) : 1'b1;
      m_mode  = nmode;
      // A button flips once its synchronized sample has disagreed for the last DB edges.
      for (int b = 0; b < 3; b++) begin
        flip[b] = 1'b1;
        for (int k = 0; k < DB; k++)
          if (raw_at(b, t - 2 - k) == m_db[b]) flip[b] = 1'b0;
        press_now[b] = flip[b] & m_db[b];
      end
      m_db    = m_db ^ flip;
      m_press = press_now;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
    if (bus.ena === 1'b1) n_ena++;
    check("ena",         8'(bus.ena),         8'(exp_ena));
    check("ena_5hz",     8'(bus.ena_5hz),     8'(exp_5hz));
    check("select_mode", 8'(bus.select_mode), 8'(m_mode));
    check("ena_up",      8'(bus.ena_up),      8'(exp_up));
    check("ena_dw",      8'(bus.ena_dw),      8'(exp_dw));
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic press_btn(input int b);
    raw[b] = 1'b0;
    run(10);
    raw[b] = 1'b1;
    run(10);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    step();
    check("rst_mode", 8'(bus.select_mode), 8'(MODE_RUN));
    check("rst_up",   8'(bus.ena_up), 8'd1);
    rst = 1'b0;

    // 1 Hz ticks at edges 10, 20, 30
    n_ena = 0;
    run(30);
    check("ena_pulses", 8'(n_ena), 8'd3);

    // Glitch is rejected, clean press reaches SET six edges after the drop
    raw[0] = 1'b0; run(2); raw[0] = 1'b1; run(10);
    check("glitch_mode", 8'(bus.select_mode), 8'(MODE_RUN));
    raw[0] = 1'b0; run(5);
    check("mode_at5", 8'(bus.select_mode), 8'(MODE_RUN));
    run(1);
    check("mode_at6", 8'(bus.select_mode), 8'(MODE_SET));
    run(4); raw[0] = 1'b1; run(10);
    press_btn(0); check("mode_hold", 8'(bus.select_mode), 8'(MODE_HOLD));
    press_btn(0); check("mode_run",  8'(bus.select_mode), 8'(MODE_RUN));
    press_btn(0); check("mode_set",  8'(bus.select_mode), 8'(MODE_SET));

    // SET: up held, immediate step then auto-repeat
    raw[1] = 1'b0; run(5);
    check("up_at5", 8'(bus.ena_up), 8'd1);
    run(1);
    check("up_at6",   8'(bus.ena_up),  8'd0);
    check("step_at6", 8'(bus.ena_5hz), 8'd1);
    run(14); raw[1] = 1'b1; run(10);
    check("up_released", 8'(bus.ena_up), 8'd1);

    // SET: up wins over down, down appears after up releases
    raw[1] = 1'b0; raw[2] = 1'b0; run(15);
    check("both_up", 8'(bus.ena_up), 8'd0);
    check("both_dw", 8'(bus.ena_dw), 8'd1);
    raw[1] = 1'b1; run(5);
    check("dw_at5", 8'(bus.ena_dw), 8'd1);
    run(1);
    check("dw_at6", 8'(bus.ena_dw), 8'd0);
    run(9); raw[2] = 1'b1; run(10);

    // RUN: down is ignored; SET: mode press while up held
    press_btn(0); press_btn(0);
    raw[2] = 1'b0; run(15);
    check("run_dw", 8'(bus.ena_dw), 8'd1);
    raw[2] = 1'b1; run(10);
    press_btn(0);
    raw[1] = 1'b0; run(10);
    raw[0] = 1'b0; run(5);
    check("leave_pre", 8'(bus.select_mode), 8'(MODE_SET));
    run(1);
    check("leave_mode", 8'(bus.select_mode), 8'(MODE_HOLD));
    check("leave_up",   8'(bus.ena_up), 8'd1);
    run(4); raw = 3'b111; run(10);

    // Simultaneous mode and up press in SET: mode wins
    press_btn(0); press_btn(0);
    raw[0] = 1'b0; raw[1] = 1'b0; run(6);
    check("simul_mode", 8'(bus.select_mode), 8'(MODE_HOLD));
    run(4); raw = 3'b111; run(10);

    // Reset mid-SET with up held
    press_btn(0); press_btn(0);
    raw[1] = 1'b0; run(10);
    rst = 1'b1; step();
    check("mid_rst_mode", 8'(bus.select_mode), 8'(MODE_RUN));
    check("mid_rst_up",   8'(bus.ena_up), 8'd1);
    check("mid_rst_ena",  8'(bus.ena), 8'd0);
    rst = 1'b0;
    run(40);
    raw[1] = 1'b1; run(10);

    // Random button activity
    for (int i = 0; i < 60; i++) begin
      raw[0] = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      raw[1] = 1'($urandom_range(0, 1));
      raw[2] = 1'($urandom_range(0, 1));
      run(int'($urandom_range(1, 12)));
    end
    raw = 3'b111;
    run(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
